// File: rtl/div_wb_unit_pkg.sv
// Shared definitions for the RV32M iterative divider write-back slice.
// Holds funct3 codes, register-file widths and divider FSM states.
package div_wb_unit_pkg;

  localparam int INST_REG_ADDR = 5;
  localparam int INST_REG_DATA = 32;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'b00,
    DIV_STATE_CALC = 2'b01,
    DIV_STATE_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_wb_unit_step.sv
// div_iter_step: one combinational restoring-division step.
// Shifts {rem, quo} left, trial-subtracts the divisor, sets one quotient bit.
module div_iter_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] shl;
  logic [W:0] diff;

  always_comb begin
    shl   = {rem_i, quo_i[W-1]};
    diff  = shl - {1'b0, dvsr_i};
    rem_o = diff[W] ? shl[W-1:0] : diff[W-1:0];
    quo_o = {quo_i[W-2:0], ~diff[W]};
  end

endmodule

// File: rtl/div_wb_unit.sv
// div_wb_unit: iterative DIV/DIVU/REM/REMU feeding the register-file write port.
// DIV_EARLY_OUT_EN lets div-by-zero, overflow and small unsigned ops skip CALC.
module div_wb_unit
  import div_wb_unit_pkg::*;
#(
  parameter int DATA_W = INST_REG_DATA,
  parameter int ADDR_W = INST_REG_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ONES = '1;
  localparam logic [DATA_W-1:0] MIN = {1'b1, {(DATA_W-1){1'b0}}};

  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvsr_q, dvsr_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic is_rem_q, is_rem_d;
  logic negq_q, negq_d;
  logic negr_q, negr_d;
  logic dbz_q, dbz_d;
  logic ovf_q, ovf_d;
  logic done_q, done_d;
  logic wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic is_signed, is_rem_op, a_neg, b_neg;
  logic dbz, ovf;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W-1:0] step_rem, step_quo;
  logic [DATA_W-1:0] q_fix, r_fix, res;
`ifdef DIV_EARLY_OUT_EN
  logic early;
`endif

  div_iter_step #(.W(DATA_W)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_comb begin
    is_signed = (funct3 == INST_DIV) || (funct3 == INST_REM);
    is_rem_op = (funct3 == INST_REM) || (funct3 == INST_REMU);
    a_neg = is_signed & dividend[DATA_W-1];
    b_neg = is_signed & divisor[DATA_W-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;
    dbz = (divisor == '0);
    ovf = is_signed && (dividend == MIN) && (divisor == ONES);
`ifdef DIV_EARLY_OUT_EN
    early = dbz | ovf | (!is_signed && (dividend < divisor));
`endif
  end

  // sign fix-up on magnitudes, then special-case overrides
  always_comb begin
    q_fix = negq_q ? -quo_q : quo_q;
    r_fix = negr_q ? -rem_q : rem_q;
    if (dbz_q) q_fix = ONES;
    if (ovf_q) begin
      q_fix = MIN;
      r_fix = '0;
    end
    res = is_rem_q ? r_fix : q_fix;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    rd_d      = rd_q;
    is_rem_d  = is_rem_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      DIV_STATE_IDLE: begin
        if (start && !flush) begin
          rd_d     = rd_addr;
          is_rem_d = is_rem_op;
          negq_d   = a_neg ^ b_neg;
          negr_d   = a_neg;
          dbz_d    = dbz;
          ovf_d    = ovf;
          cnt_d    = '0;
          rem_d    = '0;
          quo_d    = a_mag;
          dvsr_d   = b_mag;
          state_d  = DIV_STATE_CALC;
`ifdef DIV_EARLY_OUT_EN
          if (early) begin
            rem_d   = a_mag;
            quo_d   = '0;
            state_d = DIV_STATE_DONE;
          end
`endif
        end
      end
      DIV_STATE_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = DIV_STATE_DONE;
        if (flush) state_d = DIV_STATE_IDLE;
      end
      DIV_STATE_DONE: begin
        done_d    = 1'b1;
        wr_en_d   = (rd_q != '0);
        wr_addr_d = rd_q;
        wr_data_d = res;
        state_d   = DIV_STATE_IDLE;
      end
      default: state_d = DIV_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIV_STATE_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      rd_q      <= '0;
      is_rem_q  <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      rd_q      <= rd_d;
      is_rem_q  <= is_rem_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = (state_q != DIV_STATE_IDLE);
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: doc/div_wb_unit.md
Name: div_wb_unit

Overview:
- Iterative RV32M divider (DIV, DIVU, REM, REMU) that sits directly upstream of the register-file write port.
- Accepts operands and a destination register from the execute stage.
- Computes one quotient bit per cycle.
- Drives a single-cycle write-back (wr_en / wr_addr / wr_data) into the register file when finished.
- Exposes busy for pipeline stalling and flush for jump/interrupt abort.

Parameters:
- DATA_W, 32, operand/result width (XLEN).
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes treated as DIVU
- dividend  in  DATA_W  rs1 value
- divisor  in  DATA_W  rs2 value
- rd_addr  in  ADDR_W  destination register
- flush  in  1  abort in-flight operation
- busy  out  1  high from the cycle after start is accepted until result issues
- done  out  1  one-cycle completion pulse
- wr_en  out  1  register-file write enable (done AND wr_addr != 0)
- wr_addr  out  ADDR_W  destination register
- wr_data  out  DATA_W  quotient or remainder

Behaviour:
- Reset (async, immediate): state IDLE. busy, done, wr_en = 0. wr_addr, wr_data = 0. Counter and datapath registers = 0.
- State machine:
  - IDLE: start=1 and flush=0 → latch funct3, rd_addr, |dividend|, |divisor| and sign flags; counter=0; go to CALC.
  - CALC: one restoring step per cycle on {remainder, quotient} (shift left 1, trial subtract divisor, keep if non-negative, set q bit); counter increments; after step 31 go to DONE.
  - DONE: registered done=1 for one cycle; wr_en = (wr_addr != 0); wr_data/wr_addr valid; return to IDLE next cycle.
- Latency: start accepted at edge N → done/wr_en high in the cycle after edge N+33 (32 CALC cycles + DONE). Back-to-back: the next start is accepted in the cycle after DONE.
- busy = (state != IDLE) and also high during DONE, so execute stalls dependent instructions.
- Signed ops (DIV/REM): operate on magnitudes. Negate quotient if operand signs differ; negate remainder if dividend is negative. Arithmetic is modulo 2^DATA_W.
- Divide by zero: quotient = all ones (0xFFFFFFFF), remainder = dividend (signed and unsigned).
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Special cases are detected at start and the result is overridden at DONE. In the base build they still take the full 33 cycles.
- start while busy: ignored; the latched operation is unaffected.
- flush in any state: next edge → IDLE; no done, no wr_en. flush and start in the same IDLE cycle: flush wins, start dropped. flush during DONE: the write already presented this cycle still occurs.
- Reset mid-operation: abort, no write-back.
- wr_addr = 0: done still pulses, wr_en stays 0.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: divide-by-zero, signed overflow, and unsigned |dividend| < |divisor| skip CALC. IDLE → DONE directly, so done arrives in the cycle after the acceptance edge. Results are unchanged.
- Undefined: every operation takes exactly 33 cycles (deterministic timing).

Decomposition:
- Shared defines header (core defines.v) gets:
  - funct3 codes INST_DIV/INST_DIVU/INST_REM/INST_REMU;
  - DIV_STATE_IDLE/CALC/DONE encodings.
- Existing defines are reused: INST_REG_ADDR, INST_REG_DATA, ZERO_WORD, ZERO_REG_ADDR.
- One natural sub-module: div_iter_step, a combinational single restoring step with inputs remainder, quotient, divisor and outputs next remainder, next quotient. This keeps the FSM file readable and reusable for a radix-4 variant.

Test Plan:
- DIVU 100/7, rd=5 → done exactly 33 cycles after start; wr_en=1, wr_addr=5, wr_data=14. Repeat as REMU → wr_data=2.
- DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). REM 7/−2 → 1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0. DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5. Latency 33, or 1 with DIV_EARLY_OUT_EN.
- Assert start again at cycle 10 with different operands → ignored; first result intact. Then back-to-back ops → second done exactly 34 cycles after the first.
- flush at cycle 20 of CALC → no done, no wr_en; busy low next cycle. Then flush+start in the same cycle → nothing launched. rst_n low mid-CALC → outputs 0 immediately.
- rd_addr=0 DIVU 9/3 → done=1, wr_en=0.
